lsu_mem_ctrl: RTL
=================

# lsu_mem_ctrl

Parametrised load/store unit for the M stage. It issues one data-memory access per instruction over a request/grant/response bus and generates store byte strobes and lane-replicated write data. For loads it aligns and sign/zero-extends the returned lane and stalls the pipeline until the access completes. It replaces the combinational load extender between the memory read port and the M/W pipeline register, and supports XLEN 32 or 64.

## Interface
- XLEN, 32: data width; legal values 32 or 64.
- ADDR_W, 32: byte-address width.
- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  synchronous, active-high reset.
- ls_valid_M  in  1  M-stage load/store present; held stable while busy_M=1.
- ls_we_M  in  1  1=store, 0=load.
- ls_type_M  in  3  funct3 encoding:
  - loads: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
  - stores: bits[1:0] select SB/SH/SW/SD; bit2 is ignored.
- addr_M  in  ADDR_W  byte address.
- wdata_M  in  XLEN  store data, right-justified.
- busy_M  out  1  stall request to the pipeline.
- done_M  out  1  one-cycle completion pulse.
- Rdata_ext_M  out  XLEN  registered, extended load result.
- misalign_M  out  1  qualifies done_M; access faulted.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write.
- mem_addr  out  ADDR_W  word-aligned address; low log2(XLEN/8) bits are 0.
- mem_wdata  out  XLEN  lane-replicated store data.
- mem_wstrb  out  XLEN/8  byte strobes; 0 for loads.
- mem_gnt  in  1  request accepted in this cycle.
- mem_rvalid  in  1  response; also the store acknowledge.
- mem_rdata  in  XLEN  read data, valid with mem_rvalid.

## Operation
- FSM states: IDLE, REQ, RESP, DONE. Reset value is IDLE.
- IDLE:
  - If ls_valid_M=1, capture we, type, address offset, mem_addr, wdata and wstrb.
  - Go to REQ, or go straight to DONE on a trapped misalignment.
  - busy_M = ls_valid_M (combinational).
- REQ:
  - mem_req=1, with mem_we/mem_addr/mem_wdata/mem_wstrb held from the capture registers.
  - Go to RESP on mem_gnt.
  - busy_M=1.
- RESP:
  - Wait for mem_rvalid.
  - On a load, register the extended lane into Rdata_ext_M.
  - Go to DONE. busy_M=1.
- DONE:
  - done_M=1, busy_M=0, so the pipeline advances at this edge.
  - Always go to IDLE, so a request still presented in this cycle is not re-accepted.
- Access size: byte, half, word, or double (LD/SD only when XLEN=64).
- Lane offset: o = addr_M[log2(XLEN/8)-1:0].
- Load data: the lane mem_rdata[8o +: size*8] is sign-extended for LB/LH/LW and zero-extended for LBU/LHU/LWU.
- Store strobes: mem_wstrb = ((1<<size_bytes)-1) << o.
- Store data: mem_wdata holds the store data replicated across all lanes of its size.
- Unsupported type (LD/LWU/SD at XLEN=32, or 111): treated as a full-width access with no extension.
- Rdata_ext_M holds its value until the next load completes; stores and faults do not change it.
- misalign_M is a register, set in DONE and cleared in IDLE.
- mem_rvalid in IDLE, REQ or DONE is ignored.
- Reset in any state:
  - Next cycle is IDLE with mem_req=0.
  - The in-flight access is abandoned and any late mem_rvalid is ignored.

## Timing
- Reset values: busy_M (as registered state) 0, done_M 0, Rdata_ext_M 0, misalign_M 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, mem_wstrb 0.
- mem_rvalid arrives no earlier than the cycle after mem_gnt.
- Minimum latency, with gnt in the first REQ cycle and rvalid the next cycle:
  - cycle 0: IDLE accepts.
  - cycle 1: REQ with gnt.
  - cycle 2: RESP with rvalid.
  - cycle 3: DONE; done_M=1 and Rdata_ext_M valid.
- Each cycle mem_gnt stays low adds one REQ cycle; each cycle without mem_rvalid adds one RESP cycle.
- mem_* outputs are stable throughout REQ.
- A trapped misalignment completes in 2 cycles (IDLE, DONE) with no mem_req.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - An access with o not a multiple of its size goes IDLE→DONE with misalign_M=1 and no bus activity.
- LSU_MISALIGN_TRAP_EN not defined:
  - Misalignment logic is removed and misalign_M is tied to 0.
  - The offset is masked to natural alignment (o &= ~(size_bytes-1)) before computing strobes and selecting the load lane.

## Test plan
- XLEN=32, LB at addr 0x1003, mem_rdata=0x80AA_BBCC, gnt in the first REQ cycle, rvalid one cycle later -> done_M at cycle 3, Rdata_ext_M=0xFFFF_FF80, mem_addr=0x1000, mem_wstrb=0.
- LHU at 0x2002, mem_rdata=0x9ABC_1234 -> Rdata_ext_M=0x0000_9ABC. Same data with LH -> 0xFFFF_9ABC.
- SB at 0x3001 with wdata=0x0000_00A5 and gnt delayed 2 cycles -> mem_req high 3 cycles, mem_wstrb=0010, mem_wdata=0xA5A5_A5A5, busy_M high until done_M, Rdata_ext_M unchanged.
- LW at 0x4002:
  - with LSU_MISALIGN_TRAP_EN -> done_M and misalign_M at cycle 1, mem_req never asserted.
  - without the macro -> access at 0x4000 with wstrb/lane covering bytes 0-3.
- Reset asserted in RESP, then mem_rvalid arrives after reset -> state IDLE, no done_M, Rdata_ext_M=0. A following LW completes normally.
- XLEN=64, LWU at 0x8004, mem_rdata=0xF000_0001_0000_0000 -> Rdata_ext_M=0x0000_0000_F000_0001. LW at the same address and data -> 0xFFFF_FFFF_F000_0001.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl -- M-stage load/store unit.
//
// Issues one data-memory access per load/store over a req/gnt/rvalid bus,
// builds byte strobes and lane-replicated store data, and for loads selects
// and sign/zero-extends the returned lane into a registered result. The
// pipeline is stalled (busy_M) until the access completes (done_M).
//
// Optional feature: define LSU_MISALIGN_TRAP_EN to fault accesses whose
// offset is not a multiple of their size (IDLE->DONE, misalign_M=1, no bus
// traffic). Without it, the offset is forced to natural alignment instead.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ls_valid_M/we/type  M-stage access request (type = funct3)
//   addr_M, wdata_M     byte address, right-justified store data
//   busy_M, done_M      stall request, one-cycle completion pulse
//   Rdata_ext_M         registered extended load result
//   misalign_M          qualifies done_M: access faulted
//   mem_req/we/addr/wdata/wstrb   bus request side (held through REQ)
//   mem_gnt, mem_rvalid, mem_rdata bus grant and response
module lsu_mem_ctrl #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ls_valid_M,
  input  logic              ls_we_M,
  input  logic [2:0]        ls_type_M,
  input  logic [ADDR_W-1:0] addr_M,
  input  logic [XLEN-1:0]   wdata_M,
  output logic              busy_M,
  output logic              done_M,
  output logic [XLEN-1:0]   Rdata_ext_M,
  output logic              misalign_M,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  // log2 of the full-width size; larger encodings clamp to it
  localparam logic [1:0] SZ_FULL = 2'(OFFW);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;
  state_e state_q, state_d;

  logic              we_q, sgn_q, misal_q;
  logic [1:0]        sz_q;
  logic [OFFW-1:0]   off_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q, rdata_q;
  logic [NB-1:0]     wstrb_q;

  // Request decode (IDLE capture path)
  logic [1:0]      sz;
  logic [OFFW-1:0] lowmask, off;
  logic [NB-1:0]   szmask;
  logic [XLEN-1:0] wrep;
  logic            misal;

  always_comb begin
    // LD/LWU/SD at XLEN=32 and type 111 collapse to a full-width access
    sz = (ls_type_M[1:0] > SZ_FULL) ? SZ_FULL : ls_type_M[1:0];
    for (int i = 0; i < OFFW; i++) lowmask[i] = (i < int'(sz));
    for (int i = 0; i < NB; i++)   szmask[i]  = (i < (1 << sz));
`ifdef LSU_MISALIGN_TRAP_EN
    misal = |(addr_M[OFFW-1:0] & lowmask);
    off   = addr_M[OFFW-1:0];
`else
    misal = 1'b0;
    off   = addr_M[OFFW-1:0] & ~lowmask;
`endif
    wrep = '0;
    for (int i = 0; i < NB; i++) begin
      case (sz)
        2'd0:    wrep[8*i +: 8] = wdata_M[7:0];
        2'd1:    wrep[8*i +: 8] = wdata_M[8*(i%2) +: 8];
        2'd2:    wrep[8*i +: 8] = wdata_M[8*(i%4) +: 8];
        default: wrep[8*i +: 8] = wdata_M[8*i +: 8];
      endcase
    end
  end

  // Load lane select and extension (RESP path)
  logic [XLEN-1:0] lane, ext;
  logic            sbit;

  always_comb begin
    lane = mem_rdata >> {off_q, 3'b000};
    case (sz_q)
      2'd0:    sbit = lane[7];
      2'd1:    sbit = lane[15];
      2'd2:    sbit = lane[31];
      default: sbit = lane[XLEN-1];
    endcase
    ext = lane;
    for (int i = 0; i < XLEN; i++)
      if (i >= (8 << sz_q)) ext[i] = sgn_q & sbit;
  end

  // FSM next state / outputs
  always_comb begin
    state_d = state_q;
    busy_M  = 1'b0;
    done_M  = 1'b0;
    mem_req = 1'b0;
    case (state_q)
      IDLE: begin
        busy_M = ls_valid_M;
        if (ls_valid_M) state_d = misal ? DONE : REQ;
      end
      REQ: begin
        busy_M  = 1'b1;
        mem_req = 1'b1;
        if (mem_gnt) state_d = RESP;
      end
      RESP: begin
        busy_M = 1'b1;
        if (mem_rvalid) state_d = DONE;
      end
      DONE: begin
        // unconditional return so a request still held this cycle is not re-taken
        done_M  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      sz_q    <= 2'd0;
      off_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      misal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && ls_valid_M) begin
        we_q    <= ls_we_M;
        sgn_q   <= ~ls_type_M[2];
        sz_q    <= sz;
        off_q   <= off;
        addr_q  <= {addr_M[ADDR_W-1:OFFW], {OFFW{1'b0}}};
        wdata_q <= wrep;
        wstrb_q <= ls_we_M ? (szmask << off) : '0;
      end
      if (state_q == RESP && mem_rvalid && !we_q) rdata_q <= ext;
      // valid through DONE only; a trap sets it on the way in
      if (state_q == IDLE)      misal_q <= ls_valid_M & misal;
      else if (state_q == DONE) misal_q <= 1'b0;
    end
  end

  assign Rdata_ext_M = rdata_q;
  assign misalign_M  = misal_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_wstrb   = wstrb_q;

endmodule
